ad9958_spi_master: RTL and testbench
====================================

Name: ad9958_spi_master

Overview:
- Serial-port engine directly downstream of the AD9958 control sequencer.
- Accepts one frame per `trigger` pulse: a byte count (`packs_to_send`) plus right-aligned data (`data_input`).
- Shifts the frame out on the AD9958 serial port (SCLK, CS_N, SDIO[3:0]) in 1-bit or 4-bit mode and reports `busy` back to the sequencer.
- Keeps CS_N low across the instruction frame and its following data frame.

Parameters:
- CLK_DIV, 4: system clocks per SCLK half-period; legal range 1..255.
- LANES, 4: SDIO lanes; 1 drives sdio[0] only, 4 drives sdio[3:0] (must match the CSR IO_MODE written by the sequencer).
- CS_HOLD, 16: idle system clocks after a frame before CS_N deasserts if no new trigger arrives.

Ports:
- clock, input, 1: system clock.
- reset, input, 1: asynchronous, active-high reset.
- trigger, input, 1: single-cycle frame request.
- packs_to_send, input, 5: frame length in bytes.
- data_input, input, 64: frame payload, right-aligned; the byte at bits [8*n-1:8*n-8] is sent first, MSB first.
- abort, input, 1: driven from the sequencer's master_reset; cancels any transfer.
- busy, output, 1: frame accepted and not yet complete.
- sclk, output, 1: serial clock, idle low.
- cs_n, output, 1: chip select, active low.
- sdio, output, 4: serial data; unused lanes are driven 0.

Behaviour:
- Reset values: busy=0, sclk=0, cs_n=1, sdio=0, state IDLE, all counters 0.
- Acceptance:
  - trigger is sampled on every posedge while in IDLE or HOLD.
  - busy is 1 from the first posedge after trigger is sampled until the frame completes. This is required because the sequencer checks ~(busy|trigger) one cycle after its trigger.
  - A trigger while busy is ignored.
- Length rules:
  - n = packs_to_send; n=0 → trigger ignored, busy stays 0.
  - n>8 → clamped to 8.
  - The shift register latches data_input left-justified: data_input << (64-8n).
- States:
  - IDLE: cs_n=1. On trigger with n>0 → LOAD.
  - LOAD (1 cycle): cs_n=0, latch shifter, set beat count to 8n/LANES, first beat on sdio, sclk=0 → SHIFT_LO.
  - SHIFT_LO: hold CLK_DIV clocks, then sclk=1 → SHIFT_HI.
  - SHIFT_HI: hold CLK_DIV clocks, then sclk=0.
    - If beats remain: present the next beat on sdio (changes only with sclk falling) → SHIFT_LO.
    - Else: busy=0 → HOLD.
  - HOLD: cs_n stays 0.
    - Trigger with n>0 → LOAD directly.
    - After CS_HOLD clocks with no trigger: cs_n=1 → IDLE.
- Beat order:
  - LANES=4: each beat is the top nibble of the shifter; sdio[3]=bit k, sdio[0]=bit k-3.
  - LANES=1: sdio[0]=top bit.
- Frame timing: frame duration from LOAD to busy fall is 2*CLK_DIV*(8n/LANES) clocks, +1 for LOAD.
- Device samples sdio on sclk rising edge; setup is CLK_DIV system clocks.
- Abort (any state, synchronous, highest priority):
  - next cycle: sclk=0, cs_n=1, sdio=0, busy=0, state IDLE; partial frame discarded.
  - A trigger coincident with abort is ignored.
- Async reset mid-frame forces the reset values immediately.

Decomposition:
- ad9958_vars.vh: add LANES_1/LANES_4 constants and the state encodings (IDLE, LOAD, SHIFT_LO, SHIFT_HI, HOLD).
- Frame sizes reuse the existing SIZE_* defines.
- One sub-module: ad9958_sclk_gen, a half-period counter producing rise/fall strobes, enable-gated and restarted by LOAD and abort.

Test Plan:
- CLK_DIV=2, LANES=4, trigger with n=1, data_input=0x0000_0000_0000_00A5 → busy high the next cycle; sdio beats 0xA then 0x5; 2 sclk pulses; busy low after 9 clocks; cs_n high 16 clocks later.
- n=1 data=0x03 then, 3 clocks after busy falls, n=4 data=0x1234_5678 → cs_n stays low across both frames; beats 0,3,1,2,3,4,5,6,7,8.
- LANES=1, n=3 data=0x80_0001 → 24 sclk rises; sdio[0]=1 on rise 1 and rise 24 only; sdio[3:1] stay 0.
- n=0 and n=12 with data=0xFFFF_FFFF_FFFF_FFFF → n=0: busy never rises; n=12: exactly 16 beats, all 0xF.
- abort asserted mid-frame after 3 beats of an n=4 frame, plus a trigger during busy → outputs return to idle values the next cycle; the busy-period trigger produces no transfer.
- Async reset asserted between posedges mid-frame → cs_n=1, busy=0 before the next edge; the next trigger after reset release starts a clean frame.

Source files
------------

// File: rtl/ad9958_spi_master_pkg.sv
// ad9958_spi_master_pkg
//   Shared widths, lane-mode constants, FSM state encoding and frame helpers
//   for the AD9958 serial-port engine.
package ad9958_spi_master_pkg;

   localparam int unsigned DATA_W    = 64;
   localparam int unsigned PACKS_W   = 5;
   localparam int unsigned SDIO_W    = 4;
   localparam int unsigned BEAT_W    = 7;
   localparam int unsigned MAX_PACKS = 8;
   localparam int unsigned LANES_1   = 1;
   localparam int unsigned LANES_4   = 4;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      LOAD     = 3'd1,
      SHIFT_LO = 3'd2,
      SHIFT_HI = 3'd3,
      HOLD     = 3'd4
   } state_t;

   // Byte count limited to the 8 bytes the payload can carry.
   function automatic logic [3:0] clamp_packs(input logic [PACKS_W-1:0] packs);
      return (packs > PACKS_W'(MAX_PACKS)) ? 4'(MAX_PACKS) : packs[3:0];
   endfunction

   // Move the right-aligned payload so its first byte sits at the top.
   function automatic logic [DATA_W-1:0] left_justify(input logic [DATA_W-1:0] data,
                                                      input logic [PACKS_W-1:0] packs);
      logic [3:0] n;
      n = clamp_packs(packs);
      return data << (7'd64 - {n, 3'b000});
   endfunction

   // Number of SCLK beats for n bytes in the given lane mode.
   function automatic logic [BEAT_W-1:0] frame_beats(input logic [3:0] n,
                                                     input int unsigned lanes);
      return (lanes == LANES_4) ? BEAT_W'({n, 1'b0}) : BEAT_W'({n, 3'b000});
   endfunction

endpackage

// File: rtl/ad9958_spi_master_if.sv
// ad9958_spi_master_if
//   Sequencer-side request/status handshake plus the AD9958 serial pins.
//   master: sequencer (drives trigger/packs_to_send/data_input/abort)
//   slave : serial engine (drives busy/sclk/cs_n/sdio)
interface ad9958_spi_master_if;
   import ad9958_spi_master_pkg::*;

   logic                 trigger;
   logic [PACKS_W-1:0]   packs_to_send;
   logic [DATA_W-1:0]    data_input;
   logic                 abort;
   logic                 busy;
   logic                 sclk;
   logic                 cs_n;
   logic [SDIO_W-1:0]    sdio;

   modport master (
      output trigger, packs_to_send, data_input, abort,
      input  busy, sclk, cs_n, sdio
   );

   modport slave (
      input  trigger, packs_to_send, data_input, abort,
      output busy, sclk, cs_n, sdio
   );

endinterface

// File: rtl/ad9958_sclk_gen.sv
// ad9958_sclk_gen
//   Half-period counter for SCLK. Emits a rise strobe at the end of the low
//   half and a fall strobe at the end of the high half.
//   clock, reset : system clock, async active-high reset
//   enable       : count only while shifting
//   restart      : clear counter and phase (frame start or abort)
//   rise_c/fall_c: single-cycle strobes, valid in the cycle before the edge
module ad9958_sclk_gen #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic rise_c,
   output logic fall_c
);

   localparam int unsigned CNT_W = 8;

   logic [CNT_W-1:0] cnt_q;
   logic             phase_q;
   logic             wrap_c;

   assign wrap_c = enable && (cnt_q == CNT_W'(CLK_DIV - 1));
   assign rise_c = wrap_c && !phase_q;
   assign fall_c = wrap_c && phase_q;

   // Counter wraps every CLK_DIV enabled clocks; phase tracks low/high half.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (restart) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else if (enable) begin
         if (wrap_c) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
         end else begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/ad9958_spi_master.sv
// ad9958_spi_master
//   Shifts one frame per trigger out of the AD9958 serial port in 1- or 4-bit
//   mode, keeping CS_N low for CS_HOLD clocks afterwards so a following data
//   frame can reuse the same chip-select window.
//   clock, reset : system clock, async active-high reset
//   bus (slave)  : trigger/packs_to_send/data_input/abort in,
//                  busy/sclk/cs_n/sdio out (all registered)
module ad9958_spi_master
   import ad9958_spi_master_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4,
   parameter int unsigned LANES   = 4,
   parameter int unsigned CS_HOLD = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   ad9958_spi_master_if.slave   bus
);

   localparam int unsigned HOLD_W = (CS_HOLD > 1) ? $clog2(CS_HOLD) : 1;

   state_t              state_q,   state_d;
   logic [DATA_W-1:0]   shifter_q, shifter_d;
   logic [BEAT_W-1:0]   beats_q,   beats_d;
   logic [HOLD_W-1:0]   hold_q,    hold_d;
   logic                busy_q,    busy_d;
   logic                sclk_q,    sclk_d;
   logic                cs_n_q,    cs_n_d;
   logic [SDIO_W-1:0]   sdio_q,    sdio_d;

   logic                accept_c;
   logic [DATA_W-1:0]   lj_c;
   logic                rise_c;
   logic                fall_c;

   // Beat presented on the pins from the top of a shifter image.
   function automatic logic [SDIO_W-1:0] beat_of(input logic [DATA_W-1:0] s);
      if (LANES == LANES_1) return {3'b000, s[DATA_W-1]};
      return s[DATA_W-1 -: SDIO_W];
   endfunction

   ad9958_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
      .clock   (clock),
      .reset   (reset),
      .enable  ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)),
      .restart ((state_q == LOAD) || bus.abort),
      .rise_c  (rise_c),
      .fall_c  (fall_c)
   );

   assign accept_c = bus.trigger && (bus.packs_to_send != '0);
   assign lj_c     = left_justify(bus.data_input, bus.packs_to_send);

   // Next-state and next-output logic; abort overrides everything.
   always_comb begin
      state_d   = state_q;
      shifter_d = shifter_q;
      beats_d   = beats_q;
      hold_d    = hold_q;
      busy_d    = busy_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      sdio_d    = sdio_q;

      if (bus.abort) begin
         state_d   = IDLE;
         shifter_d = '0;
         beats_d   = '0;
         hold_d    = '0;
         busy_d    = 1'b0;
         sclk_d    = 1'b0;
         cs_n_d    = 1'b1;
         sdio_d    = '0;
      end else begin
         case (state_q)
            IDLE, HOLD: begin
               if (accept_c) begin
                  // Latch the frame at acceptance so LOAD already drives beat 0.
                  state_d   = LOAD;
                  shifter_d = lj_c;
                  beats_d   = frame_beats(clamp_packs(bus.packs_to_send), LANES) - BEAT_W'(1);
                  hold_d    = '0;
                  busy_d    = 1'b1;
                  sclk_d    = 1'b0;
                  cs_n_d    = 1'b0;
                  sdio_d    = beat_of(lj_c);
               end else if (state_q == HOLD) begin
                  if (hold_q == HOLD_W'(CS_HOLD - 1)) begin
                     state_d = IDLE;
                     cs_n_d  = 1'b1;
                     hold_d  = '0;
                  end else begin
                     hold_d = hold_q + HOLD_W'(1);
                  end
               end
            end
            LOAD: begin
               state_d = SHIFT_LO;
               sclk_d  = 1'b0;
            end
            SHIFT_LO: begin
               if (rise_c) begin
                  state_d = SHIFT_HI;
                  sclk_d  = 1'b1;
               end
            end
            SHIFT_HI: begin
               if (fall_c) begin
                  sclk_d = 1'b0;
                  if (beats_q != '0) begin
                     // Data changes only together with the falling SCLK edge.
                     shifter_d = shifter_q << LANES;
                     sdio_d    = beat_of(shifter_d);
                     beats_d   = beats_q - BEAT_W'(1);
                     state_d   = SHIFT_LO;
                  end else begin
                     busy_d  = 1'b0;
                     hold_d  = '0;
                     state_d = HOLD;
                  end
               end
            end
            default: begin
               state_d = IDLE;
               busy_d  = 1'b0;
               sclk_d  = 1'b0;
               cs_n_d  = 1'b1;
               sdio_d  = '0;
            end
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         shifter_q <= '0;
         beats_q   <= '0;
         hold_q    <= '0;
         busy_q    <= 1'b0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         sdio_q    <= '0;
      end else begin
         state_q   <= state_d;
         shifter_q <= shifter_d;
         beats_q   <= beats_d;
         hold_q    <= hold_d;
         busy_q    <= busy_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         sdio_q    <= sdio_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.sclk = sclk_q;
   assign bus.cs_n = cs_n_q;
   assign bus.sdio = sdio_q;

endmodule

// File: tb/tb_ad9958_spi_master.sv
// tb_ad9958_spi_master
//   Directed bench: a 4-lane and a 1-lane engine (CLK_DIV=2, CS_HOLD=16)
//   sharing clock and reset; frames are driven and observed on negedges.
module tb_ad9958_spi_master;

   logic clock;
   logic reset;

   ad9958_spi_master_if bus4 ();
   ad9958_spi_master_if bus1 ();

   ad9958_spi_master #(.CLK_DIV(2), .LANES(4), .CS_HOLD(16)) dut4 (
      .clock (clock),
      .reset (reset),
      .bus   (bus4)
   );

   ad9958_spi_master #(.CLK_DIV(2), .LANES(1), .CS_HOLD(16)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;

   bit          sel1;
   logic        o_busy, o_sclk, o_cs_n;
   logic [3:0]  o_sdio;

   assign o_busy = sel1 ? bus1.busy : bus4.busy;
   assign o_sclk = sel1 ? bus1.sclk : bus4.sclk;
   assign o_cs_n = sel1 ? bus1.cs_n : bus4.cs_n;
   assign o_sdio = sel1 ? bus1.sdio : bus4.sdio;

   int          busy_cyc;
   int          beats_n;
   logic [63:0] beats_val;
   logic [2:0]  hi_or;
   bit          cs_hi;
   bit          start_busy;
   int          cs_cyc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic trig, input logic [4:0] n, input logic [63:0] d);
      if (sel1) begin
         bus1.trigger = trig; bus1.packs_to_send = n; bus1.data_input = d;
      end else begin
         bus4.trigger = trig; bus4.packs_to_send = n; bus4.data_input = d;
      end
   endtask

   // One trigger, then record rising-edge beats until busy drops (bounded).
   task automatic run_frame(input logic [4:0] n, input logic [63:0] d);
      bit prev_sclk;
      @(negedge clock);
      drive(1'b1, n, d);
      @(negedge clock);
      drive(1'b0, 5'd0, 64'd0);
      busy_cyc   = 0;
      beats_n    = 0;
      beats_val  = '0;
      hi_or      = '0;
      cs_hi      = 1'b0;
      prev_sclk  = 1'b0;
      start_busy = o_busy;
      while (o_busy && busy_cyc < 200) begin
         if (o_sclk && !prev_sclk) begin
            beats_n++;
            beats_val = sel1 ? {beats_val[62:0], o_sdio[0]} : {beats_val[59:0], o_sdio};
         end
         hi_or     = hi_or | o_sdio[3:1];
         cs_hi     = cs_hi | o_cs_n;
         prev_sclk = o_sclk;
         busy_cyc++;
         @(negedge clock);
      end
   endtask

   task automatic wait_cs_high();
      cs_cyc = 0;
      while (!o_cs_n && cs_cyc < 100) begin
         @(negedge clock);
         cs_cyc++;
      end
   endtask

   initial begin
      int  rises;
      bit  prev;
      bit  flag;

      sel1 = 1'b0;
      reset = 1'b1;
      bus4.trigger = 1'b0; bus4.packs_to_send = '0; bus4.data_input = '0; bus4.abort = 1'b0;
      bus1.trigger = 1'b0; bus1.packs_to_send = '0; bus1.data_input = '0; bus1.abort = 1'b0;
      repeat (3) @(negedge clock);

      check("rst_busy", 64'(bus4.busy), 64'd0);
      check("rst_sclk", 64'(bus4.sclk), 64'd0);
      check("rst_cs_n", 64'(bus4.cs_n), 64'd1);
      check("rst_sdio", 64'(bus4.sdio), 64'd0);
      check("rst_cs_n_l1", 64'(bus1.cs_n), 64'd1);
      reset = 1'b0;

      // Single byte, 4 lanes.
      run_frame(5'd1, 64'hA5);
      check("t1_busy_next", 64'(start_busy), 64'd1);
      check("t1_busy_cyc", 64'(busy_cyc), 64'd9);
      check("t1_beats_n", 64'(beats_n), 64'd2);
      check("t1_beats", beats_val, 64'hA5);
      check("t1_cs_low", 64'(cs_hi), 64'd0);
      wait_cs_high();
      check("t1_cs_hold", 64'(cs_cyc), 64'd16);

      // Instruction byte then data word inside one CS_N window.
      run_frame(5'd1, 64'h03);
      check("t2a_beats", beats_val, 64'h03);
      check("t2a_beats_n", 64'(beats_n), 64'd2);
      repeat (2) @(negedge clock);
      check("t2_gap_cs", 64'(o_cs_n), 64'd0);
      run_frame(5'd4, 64'h1234_5678);
      check("t2b_beats", beats_val, 64'h1234_5678);
      check("t2b_beats_n", 64'(beats_n), 64'd8);
      check("t2b_busy_cyc", 64'(busy_cyc), 64'd33);
      check("t2b_cs_low", 64'(cs_hi), 64'd0);
      wait_cs_high();
      check("t2_cs_hold", 64'(cs_cyc), 64'd16);

      // Single lane, 3 bytes.
      sel1 = 1'b1;
      run_frame(5'd3, 64'h80_0001);
      check("t3_beats_n", 64'(beats_n), 64'd24);
      check("t3_bits", beats_val, 64'h80_0001);
      check("t3_hi_lanes", 64'(hi_or), 64'd0);
      check("t3_busy_cyc", 64'(busy_cyc), 64'd97);
      wait_cs_high();
      check("t3_cs_hold", 64'(cs_cyc), 64'd16);
      sel1 = 1'b0;

      // Zero length ignored; oversize clamped to 8 bytes.
      run_frame(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t4_n0_busy", 64'(start_busy), 64'd0);
      check("t4_n0_beats", 64'(beats_n), 64'd0);
      check("t4_n0_cs", 64'(o_cs_n), 64'd1);
      run_frame(5'd12, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t4_n12_beats_n", 64'(beats_n), 64'd16);
      check("t4_n12_beats", beats_val, 64'hFFFF_FFFF_FFFF_FFFF);
      check("t4_n12_busy_cyc", 64'(busy_cyc), 64'd65);
      wait_cs_high();

      // Abort after three beats, with triggers during busy and with abort.
      @(negedge clock);
      drive(1'b1, 5'd4, 64'h1234_5678);
      @(negedge clock);
      drive(1'b0, 5'd0, 64'd0);
      rises = 0; prev = 1'b0; cs_cyc = 0;
      while (rises < 3 && cs_cyc < 100) begin
         @(negedge clock);
         cs_cyc++;
         if (bus4.sclk && !prev) rises++;
         prev = bus4.sclk;
      end
      check("t5_three_rises", 64'(rises), 64'd3);
      drive(1'b1, 5'd2, 64'hFFFF);
      @(negedge clock);
      drive(1'b0, 5'd0, 64'd0);
      check("t5_busy_trig_busy", 64'(bus4.busy), 64'd1);
      check("t5_busy_trig_sclk", 64'(bus4.sclk), 64'd1);
      check("t5_busy_trig_sdio", 64'(bus4.sdio), 64'h3);
      bus4.abort = 1'b1;
      drive(1'b1, 5'd1, 64'hA5);
      @(negedge clock);
      bus4.abort = 1'b0;
      drive(1'b0, 5'd0, 64'd0);
      check("t5_abort_busy", 64'(bus4.busy), 64'd0);
      check("t5_abort_cs_n", 64'(bus4.cs_n), 64'd1);
      check("t5_abort_sclk", 64'(bus4.sclk), 64'd0);
      check("t5_abort_sdio", 64'(bus4.sdio), 64'd0);
      flag = 1'b0;
      repeat (20) begin
         @(negedge clock);
         if (bus4.busy || bus4.sclk || !bus4.cs_n) flag = 1'b1;
      end
      check("t5_no_transfer", 64'(flag), 64'd0);

      // Asynchronous reset mid-frame, then a clean frame.
      @(negedge clock);
      drive(1'b1, 5'd4, 64'h1234_5678);
      @(negedge clock);
      drive(1'b0, 5'd0, 64'd0);
      repeat (4) @(negedge clock);
      check("t6_pre_busy", 64'(bus4.busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      check("t6_rst_cs_n", 64'(bus4.cs_n), 64'd1);
      check("t6_rst_busy", 64'(bus4.busy), 64'd0);
      check("t6_rst_sdio", 64'(bus4.sdio), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      run_frame(5'd1, 64'hA5);
      check("t6_busy_cyc", 64'(busy_cyc), 64'd9);
      check("t6_beats", beats_val, 64'hA5);
      check("t6_beats_n", 64'(beats_n), 64'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
